// File: rtl/control_cursor_rgb_pkg.sv
// control_cursor_rgb_pkg
// Shared constants for the cursor/ring colour block: FSM states, field indices,
// field box geometry (also used by the RGB selector) and colour values.
package control_cursor_rgb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_HIDE
    } state_t;

    // Field indices: hour 0-2, date 3-5, timer 6-8
    localparam logic [3:0] FIELD_HOUR1  = 4'd0;
    localparam logic [3:0] FIELD_HOUR2  = 4'd1;
    localparam logic [3:0] FIELD_HOUR3  = 4'd2;
    localparam logic [3:0] FIELD_DATE1  = 4'd3;
    localparam logic [3:0] FIELD_DATE2  = 4'd4;
    localparam logic [3:0] FIELD_DATE3  = 4'd5;
    localparam logic [3:0] FIELD_TIMER1 = 4'd6;
    localparam logic [3:0] FIELD_TIMER2 = 4'd7;
    localparam logic [3:0] FIELD_TIMER3 = 4'd8;

    // Box geometry: every box is 64x64 pixels, given by its top-left corner
    localparam logic [9:0] BOX_SPAN    = 10'd63;
    localparam logic [9:0] HT_COL0_X   = 10'd192;
    localparam logic [9:0] HT_COL1_X   = 10'd320;
    localparam logic [9:0] HT_COL2_X   = 10'd448;
    localparam logic [9:0] DT_COL0_X   = 10'd160;
    localparam logic [9:0] DT_COL1_X   = 10'd320;
    localparam logic [9:0] DT_COL2_X   = 10'd480;
    localparam logic [9:0] HOUR_ROW_Y  = 10'd64;
    localparam logic [9:0] DATE_ROW_Y  = 10'd192;
    localparam logic [9:0] TIMER_ROW_Y = 10'd320;

    // Colours (12-bit RGB 4:4:4)
    localparam logic [11:0] HILITE    = 12'hFF0;
    localparam logic [11:0] NORMAL    = 12'hFFF;
    localparam logic [11:0] RING_ON   = 12'hF00;
    localparam logic [11:0] RING_IDLE = 12'h888;
    localparam logic [11:0] BLACK     = 12'h000;

    // Inclusive range check [lo, lo+63]; largest corner + 63 still fits 10 bits
    function automatic logic in_span(input logic [9:0] v, input logic [9:0] lo);
        return (v >= lo) && (v <= lo + BOX_SPAN);
    endfunction

endpackage

// File: rtl/control_cursor_rgb_field_box_lookup.sv
// field_box_lookup
// Combinational: is pixel (pix_x, pix_y) inside the box of field cursor_idx?
// Ports: cursor_idx[3:0], pix_x[9:0], pix_y[9:0] in; in_box out (0 for idx>8).
module field_box_lookup
    import control_cursor_rgb_pkg::*;
(
    input  logic [3:0] cursor_idx,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic       in_box
);

    logic [9:0] x0;
    logic [9:0] y0;
    logic       valid;

    always_comb begin
        x0    = '0;
        y0    = '0;
        valid = 1'b1;
        case (cursor_idx)
            FIELD_HOUR1:  begin x0 = HT_COL0_X; y0 = HOUR_ROW_Y;  end
            FIELD_HOUR2:  begin x0 = HT_COL1_X; y0 = HOUR_ROW_Y;  end
            FIELD_HOUR3:  begin x0 = HT_COL2_X; y0 = HOUR_ROW_Y;  end
            FIELD_DATE1:  begin x0 = DT_COL0_X; y0 = DATE_ROW_Y;  end
            FIELD_DATE2:  begin x0 = DT_COL1_X; y0 = DATE_ROW_Y;  end
            FIELD_DATE3:  begin x0 = DT_COL2_X; y0 = DATE_ROW_Y;  end
            FIELD_TIMER1: begin x0 = HT_COL0_X; y0 = TIMER_ROW_Y; end
            FIELD_TIMER2: begin x0 = HT_COL1_X; y0 = TIMER_ROW_Y; end
            FIELD_TIMER3: begin x0 = HT_COL2_X; y0 = TIMER_ROW_Y; end
            default:      valid = 1'b0;
        endcase
        in_box = valid && in_span(pix_x, x0) && in_span(pix_y, y0);
    end

endmodule

// File: rtl/control_cursor_rgb.sv
// control_cursor_rgb
// Edit-mode cursor (field select + blink) and ring-flash colour generation.
// Ports: clk, reset (sync, active high), frame_tick, edit_en, btn_right,
//        btn_left, ring_active, video_on, pix_x/pix_y[9:0] in;
//        cursor_idx[3:0], blink_on, rgb_numero[11:0], rgb_ring[11:0] out.
module control_cursor_rgb
    import control_cursor_rgb_pkg::*;
#(
    parameter int BLINK_FRAMES = 30,
    parameter int RING_FRAMES  = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        edit_en,
    input  logic        btn_right,
    input  logic        btn_left,
    input  logic        ring_active,
    input  logic        video_on,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    output logic [3:0]  cursor_idx,
    output logic        blink_on,
    output logic [11:0] rgb_numero,
    output logic [11:0] rgb_ring
);

    state_t     state, state_n;
    logic [5:0] blink_cnt, blink_cnt_n;
    logic [3:0] idx_n;
    logic [4:0] ring_cnt, ring_cnt_n;
    logic       ring_phase, ring_phase_n;
    logic       in_box;
    logic       move;

    field_box_lookup u_box (
        .cursor_idx (cursor_idx),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .in_box     (in_box)
    );

    // Both buttons at once cancel out and count as no move
    assign move     = (state != ST_IDLE) && (btn_right ^ btn_left);
    assign blink_on = (state != ST_HIDE);

    always_comb begin
        state_n     = state;
        blink_cnt_n = blink_cnt;
        idx_n       = cursor_idx;
        if (state == ST_IDLE) begin
            if (edit_en) begin
                state_n     = ST_SHOW;
                blink_cnt_n = '0;
            end
        end else begin
            // A move wins over a coincident blink expiry
            if (move) begin
                if (btn_right) idx_n = (cursor_idx == FIELD_TIMER3) ? FIELD_HOUR1  : cursor_idx + 4'd1;
                else           idx_n = (cursor_idx == FIELD_HOUR1)  ? FIELD_TIMER3 : cursor_idx - 4'd1;
                state_n     = ST_SHOW;
                blink_cnt_n = '0;
            end else if (frame_tick) begin
                if (blink_cnt == 6'(BLINK_FRAMES - 1)) begin
                    blink_cnt_n = '0;
                    state_n     = (state == ST_SHOW) ? ST_HIDE : ST_SHOW;
                end else begin
                    blink_cnt_n = blink_cnt + 6'd1;
                end
            end
            if (!edit_en) begin
                state_n     = ST_IDLE;
                blink_cnt_n = '0;
            end
        end
    end

    // Ring counter and phase are pinned at 0 while not ringing so every
    // new ring starts on the red phase
    always_comb begin
        ring_cnt_n   = ring_cnt;
        ring_phase_n = ring_phase;
        if (!ring_active) begin
            ring_cnt_n   = '0;
            ring_phase_n = 1'b0;
        end else if (frame_tick) begin
            if (ring_cnt == 5'(RING_FRAMES - 1)) begin
                ring_cnt_n   = '0;
                ring_phase_n = ~ring_phase;
            end else begin
                ring_cnt_n = ring_cnt + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            blink_cnt  <= '0;
            cursor_idx <= FIELD_HOUR1;
            ring_cnt   <= '0;
            ring_phase <= 1'b0;
        end else begin
            state      <= state_n;
            blink_cnt  <= blink_cnt_n;
            cursor_idx <= idx_n;
            ring_cnt   <= ring_cnt_n;
            ring_phase <= ring_phase_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_numero <= BLACK;
            rgb_ring   <= RING_IDLE;
        end else begin
            if (!video_on)                       rgb_numero <= BLACK;
            else if (in_box && state == ST_SHOW) rgb_numero <= HILITE;
            else if (in_box && state == ST_HIDE) rgb_numero <= BLACK;
            else                                 rgb_numero <= NORMAL;

            if (!ring_active)    rgb_ring <= RING_IDLE;
            else if (ring_phase) rgb_ring <= BLACK;
            else                 rgb_ring <= RING_ON;
        end
    end

endmodule

// File: tb/tb_control_cursor_rgb.sv
module tb_control_cursor_rgb;
    localparam int BF = 30;
    localparam int RF = 15;

    logic clk = 1'b0;
    logic reset, frame_tick, edit_en, btn_right, btn_left, ring_active, video_on;
    logic [9:0] pix_x, pix_y;
    logic [3:0] cursor_idx;
    logic blink_on;
    logic [11:0] rgb_numero, rgb_ring;

    always #5 clk = ~clk;

    control_cursor_rgb #(.BLINK_FRAMES(BF), .RING_FRAMES(RF)) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .edit_en(edit_en),
        .btn_right(btn_right), .btn_left(btn_left), .ring_active(ring_active),
        .video_on(video_on), .pix_x(pix_x), .pix_y(pix_y),
        .cursor_idx(cursor_idx), .blink_on(blink_on),
        .rgb_numero(rgb_numero), .rgb_ring(rgb_ring)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: edit mode flag, frames since the blink last restarted,
    // selected field, frames counted while ringing
    int m_edit, m_bf, m_idx, m_rf;
    logic [11:0] m_rgbn, m_rgbr;

    int cols_ht[3] = '{192, 320, 448};
    int cols_dt[3] = '{160, 320, 480};
    int rows[3]    = '{64, 192, 320};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit box_hit(input int idx, input int x, input int y);
        int cx, ry;
        if (idx < 0 || idx > 8) return 1'b0;
        ry = rows[idx / 3];
        cx = (idx / 3 == 1) ? cols_dt[idx % 3] : cols_ht[idx % 3];
        return (x >= cx) && (x < cx + 64) && (y >= ry) && (y < ry + 64);
    endfunction

    function automatic bit m_hidden();
        return (m_edit != 0) && ((m_bf / BF) % 2 == 1);
    endfunction

    task automatic model_step();
        if (reset) begin
            m_edit = 0; m_bf = 0; m_idx = 0; m_rf = 0;
            m_rgbn = 12'h000; m_rgbr = 12'h888;
        end else begin
            if (!video_on) m_rgbn = 12'h000;
            else if (m_edit != 0 && box_hit(m_idx, int'(pix_x), int'(pix_y)))
                m_rgbn = m_hidden() ? 12'h000 : 12'hFF0;
            else m_rgbn = 12'hFFF;

            if (!ring_active) m_rgbr = 12'h888;
            else m_rgbr = ((m_rf / RF) % 2 == 1) ? 12'h000 : 12'hF00;

            if (!ring_active) m_rf = 0;
            else if (frame_tick) m_rf++;

            if (m_edit != 0) begin
                if (btn_right ^ btn_left) begin
                    m_idx = btn_right ? (m_idx + 1) % 9 : (m_idx + 8) % 9;
                    m_bf = 0;
                end else if (frame_tick) m_bf++;
                if (!edit_en) begin m_edit = 0; m_bf = 0; end
            end else if (edit_en) begin
                m_edit = 1; m_bf = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("cursor_idx", 32'(cursor_idx), 32'(m_idx));
        chk("blink_on", 32'(blink_on), 32'(!m_hidden()));
        chk("rgb_numero", 32'(rgb_numero), 32'(m_rgbn));
        chk("rgb_ring", 32'(rgb_ring), 32'(m_rgbr));
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1; tick();
            frame_tick = 1'b0; tick();
        end
    endtask

    task automatic press(input logic r, input logic l);
        btn_right = r; btn_left = l; tick();
        btn_right = 1'b0; btn_left = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_idx"}, 32'(cursor_idx), 32'd0);
        chk({tag, "_blink"}, 32'(blink_on), 32'd1);
        chk({tag, "_rgbn"}, 32'(rgb_numero), 32'h000);
        chk({tag, "_rgbr"}, 32'(rgb_ring), 32'h888);
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; edit_en = 1'b0; btn_right = 1'b0;
        btn_left = 1'b0; ring_active = 1'b0; video_on = 1'b1;
        pix_x = 10'd200; pix_y = 10'd70;
        m_edit = 0; m_bf = 0; m_idx = 0; m_rf = 0; m_rgbn = '0; m_rgbr = '0;
        tick(); tick();
        check_reset_vals("reset");

        // Blink half-periods
        reset = 1'b0; edit_en = 1'b1; tick();
        chk("enter_show", 32'(blink_on), 32'd1);
        frames(BF);
        chk("blink_hide", 32'(blink_on), 32'd0);
        frames(BF);
        chk("blink_show", 32'(blink_on), 32'd1);

        // Wrap-around and simultaneous buttons
        press(1'b0, 1'b1);
        chk("wrap_left0", 32'(cursor_idx), 32'd8);
        press(1'b1, 1'b0);
        chk("wrap_right8", 32'(cursor_idx), 32'd0);
        press(1'b0, 1'b1);
        chk("left_again", 32'(cursor_idx), 32'd8);
        press(1'b1, 1'b1);
        chk("both_btn", 32'(cursor_idx), 32'd8);

        // Move in HIDE restarts blink from SHOW with counter cleared
        frames(BF);
        chk("hide_again", 32'(blink_on), 32'd0);
        frames(10);
        press(1'b1, 1'b0);
        chk("move_show", 32'(blink_on), 32'd1);
        frames(BF - 1);
        chk("cnt_cleared", 32'(blink_on), 32'd1);
        frames(1);
        chk("cnt_expire", 32'(blink_on), 32'd0);

        // Highlight colour for the selected date box
        for (int i = 0; i < 4; i++) press(1'b1, 1'b0);
        chk("idx4", 32'(cursor_idx), 32'd4);
        pix_x = 10'd330; pix_y = 10'd200; tick();
        chk("hilite", 32'(rgb_numero), 32'hFF0);
        pix_x = 10'd170; tick();
        chk("normal", 32'(rgb_numero), 32'hFFF);
        video_on = 1'b0; tick();
        chk("blank", 32'(rgb_numero), 32'h000);
        video_on = 1'b1;

        // Ring flash
        ring_active = 1'b1; tick();
        chk("ring_red0", 32'(rgb_ring), 32'hF00);
        frames(RF - 1);
        chk("ring_red14", 32'(rgb_ring), 32'hF00);
        frames(1);
        chk("ring_dark", 32'(rgb_ring), 32'h000);
        frames(5);
        ring_active = 1'b0; tick();
        chk("ring_idle", 32'(rgb_ring), 32'h888);
        ring_active = 1'b1; tick();
        chk("ring_restart", 32'(rgb_ring), 32'hF00);

        // Reset during HIDE with ring phase 1
        ring_active = 1'b0; tick();
        press(1'b1, 1'b0);
        ring_active = 1'b1; tick();
        frames(45);
        chk("pre_rst_hide", 32'(blink_on), 32'd0);
        chk("pre_rst_ring", 32'(rgb_ring), 32'h000);
        reset = 1'b1; tick();
        check_reset_vals("mid_reset");
        reset = 1'b0; tick();
        chk("post_rst_ring", 32'(rgb_ring), 32'hF00);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) edit_en = ~edit_en;
            if ($urandom_range(0, 149) == 0) ring_active = ~ring_active;
            reset      = ($urandom_range(0, 1499) == 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            btn_right  = ($urandom_range(0, 9) == 0);
            btn_left   = ($urandom_range(0, 9) == 0);
            video_on   = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) == 0) begin
                pix_x = 10'($urandom_range(150, 560));
                pix_y = 10'($urandom_range(50, 400));
            end else begin
                pix_x = 10'($urandom_range(0, 639));
                pix_y = 10'($urandom_range(0, 479));
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/control_cursor_rgb.md
CONTROL_CURSOR_RGB -- requirements
Module: control_cursor_rgb

Interface
REQ-001 Parameter BLINK_FRAMES, default 30: frames per cursor blink half-period.
REQ-002 Parameter RING_FRAMES, default 15: frames per ring-flash half-period.
REQ-003 clk  in  1  system clock; the single clock domain.
REQ-004 reset  in  1  reset; one clock, synchronous and active-high.
REQ-005 frame_tick  in  1  one-cycle pulse per VGA frame (first cycle of vertical blanking).
REQ-006 edit_en  in  1  level; user is in edit mode.
REQ-007 btn_right  in  1  one-cycle pulse (debounced); move cursor forward.
REQ-008 btn_left  in  1  one-cycle pulse (debounced); move cursor backward.
REQ-009 ring_active  in  1  level; alarm/timer ringing.
REQ-010 video_on  in  1  active display area.
REQ-011 pix_x, pix_y  in  10 each  current pixel coordinates.
REQ-012 cursor_idx  out  4  selected field: 0-2 hour1..hour3, 3-5 date1..date3, 6-8 timer1..timer3.
REQ-013 blink_on  out  1  1 while the cursor field is shown, 0 while it is hidden.
REQ-014 rgb_numero  out  12  colour fed to the selector for digit regions.
REQ-015 rgb_ring  out  12  colour fed to the selector for the RING region.

Function
REQ-016 The FSM SHALL have states IDLE, SHOW, and HIDE; reset enters IDLE.
REQ-017 IDLE->SHOW when edit_en=1; SHOW/HIDE->IDLE in the cycle after edit_en=0, from any state.
REQ-018 In SHOW/HIDE, a 6-bit frame counter SHALL increment on frame_tick; on reaching BLINK_FRAMES-1 with frame_tick, it SHALL clear and toggle SHOW<->HIDE.
REQ-019 blink_on SHALL be 1 in SHOW and IDLE, and 0 in HIDE.
REQ-020 Cursor moves SHALL be accepted only in SHOW/HIDE: btn_right gives idx+1 with 8->0 wrap, and btn_left gives idx-1 with 0->8 wrap.
REQ-021 btn_right and btn_left in the same cycle SHALL leave cursor_idx unchanged.
REQ-022 An accepted move SHALL force state SHOW and clear the blink counter in the same edge.
REQ-023 A move and a blink-counter expiry in the same cycle SHALL be handled as the move; the expiry is discarded.
REQ-024 cursor_idx SHALL be retained through IDLE; only reset returns it to 0.
REQ-025 Field boxes SHALL be as follows. Hour and timer columns x 192-255, 320-383, 448-511, with hour rows y 64-127 and timer rows y 320-383. Date columns x 160-223, 320-383, 480-543, with y 192-255. All bounds are inclusive.
REQ-026 rgb_numero SHALL be registered with 1-cycle latency from pix_x/pix_y/video_on, and SHALL be decided as follows.
- video_on=0 -> 12'h000.
- Pixel in the box of cursor_idx and state SHOW -> HILITE 12'hFF0.
- Pixel in the box of cursor_idx and state HIDE -> 12'h000.
- Otherwise -> NORMAL 12'hFFF.
REQ-027 The ring flash SHALL use a separate 5-bit frame counter. While ring_active=1 it counts frame_tick and toggles a ring_phase bit at RING_FRAMES-1. When ring_active=0, both the counter and ring_phase SHALL be held at 0.
REQ-028 rgb_ring SHALL be registered: 12'hF00 when ring_active and ring_phase=0; 12'h000 when ring_active and ring_phase=1; 12'h888 when ring_active=0.
REQ-029 Ring and cursor logic SHALL be independent; simultaneous edit and ring SHALL both operate.
REQ-030 frame_tick with no edge effects SHALL NOT alter cursor_idx.

Reset
REQ-031 On reset=1 at a clk edge, outputs SHALL be: state IDLE, cursor_idx 0, blink_on 1, both counters 0, ring_phase 0, rgb_numero 12'h000, rgb_ring 12'h888.
REQ-032 Reset asserted mid-blink or mid-ring SHALL take effect on that edge, with no residual phase.
REQ-033 All register resets SHALL be synchronous; there SHALL be no asynchronous reset path.

Structure
REQ-034 The shared package SHALL hold:
- field box coordinate constants, shared with the RGB selector;
- colour constants HILITE, NORMAL, RING_ON, RING_IDLE;
- the FSM state enum;
- the field index constants 0-8.
REQ-035 One sub-module, field_box_lookup, SHALL be combinational: (cursor_idx, pix_x, pix_y) -> in_box. It SHALL return 0 for idx>8.
REQ-036 The implementation SHALL be one clocked process for the FSM and counters, plus the registered colour muxes.

Verification
REQ-037 Reset, then edit_en=1 and 30 frame_ticks -> state HIDE, blink_on=0; 30 more -> SHOW.
REQ-038 cursor_idx=8, btn_right -> cursor_idx=0; then btn_left -> 8; btn_left+btn_right together -> unchanged.
REQ-039 In HIDE at frame count 10, btn_right -> SHOW, counter 0, and blink_on=1 on the next cycle.
REQ-040 cursor_idx=4 in SHOW, pix (330,200), video_on=1 -> rgb_numero=12'hFF0 one cycle later; pix (170,200) -> 12'hFFF; video_on=0 -> 12'h000.
REQ-041 ring_active=1 -> rgb_ring F00 for 15 frames, then 000 for 15 frames; ring_active dropped mid-phase -> 888 next cycle, and phase restarts at F00 on re-assert.
REQ-042 Reset pulsed during HIDE with ring phase 1 -> all REQ-031 values on the next cycle.
